// File: rtl/spi_tft_pkg.sv
// Shared definitions for the SPI TFT command link: opcodes, decoder states
// and the power-on values of the MADCTL/COLMOD registers.
package spi_tft_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_NORON   = 8'h13;
  localparam logic [7:0] CMD_INVOFF  = 8'h20;
  localparam logic [7:0] CMD_INVON   = 8'h21;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [7:0] MADCTL_RST  = 8'h00;
  localparam logic [7:0] COLMOD_RST  = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PARAM  = 2'd1,
    S_RAMWR  = 2'd2,
    S_IGNORE = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spi_tft_byte_rx.sv
// SPI mode-0 byte receiver running entirely in the sys_clk domain.
// All pins are double-synchronised; SCLK rises are found on the synchronised
// copy so MOSI and DC are seen with the same latency and need no extra skew.
module spi_tft_byte_rx (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_dc_i,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       cs_high
);

  logic [1:0] sclk_sync, mosi_sync, cs_sync, dc_sync;
  logic       sclk_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign cs_high   = cs_sync[1];

  // Two-flop synchronisers; CS resets to the deselected level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      cs_sync   <= {cs_sync[0], spi_cs_n_i};
      dc_sync   <= {dc_sync[0], spi_dc_i};
    end
  end

  // Shift on each SCLK rise; the 8th bit completes the byte and captures DC.
  // A deselect clears the bit count so a partial byte never leaks forward.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_d   <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      byte_stb <= 1'b0;
      rx_byte  <= 8'h00;
      rx_dc    <= 1'b0;
    end else begin
      sclk_d   <= sclk_sync[1];
      byte_stb <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_stb <= 1'b1;
          rx_byte  <= {shift, mosi_sync[1]};
          rx_dc    <= dc_sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/spi_tft_cmd_decoder.sv
// Display-side ST7789-class command decoder: tracks window, mode and power
// registers and streams RAMWR pixels with their (x,y) coordinates.
//
//  state    | meaning
//  S_IDLE   | no command open; a parameter byte is unexpected
//  S_PARAM  | collecting parameters for COLMOD/MADCTL/CASET/RASET
//  S_RAMWR  | pixel stream open, two bytes per RGB565 pixel
//  S_IGNORE | unsupported opcode; its parameters are silently dropped
module spi_tft_cmd_decoder
  import spi_tft_pkg::*;
#(
  parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
  parameter logic [15:0] SCREEN_HEIGHT = 16'd240
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_dc_i,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_code_o,
  output logic        pixel_valid_o,
  output logic [15:0] pixel_data_o,
  output logic [15:0] pixel_x_o,
  output logic [15:0] pixel_y_o,
  output logic        frame_done_o,
  output logic        disp_on_o,
  output logic        sleep_o,
  output logic        inv_on_o,
  output logic [7:0]  madctl_o,
  output logic [7:0]  colmod_o,
  output logic        err_unexp_o
);

  localparam logic [15:0] XE_RST = SCREEN_WIDTH - 16'd1;
  localparam logic [15:0] YE_RST = SCREEN_HEIGHT - 16'd1;

  logic       byte_stb, rx_dc, cs_high;
  logic [7:0] rx_byte;

  spi_tft_byte_rx u_byte_rx (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .spi_sclk_i (spi_sclk_i),
    .spi_mosi_i (spi_mosi_i),
    .spi_cs_n_i (spi_cs_n_i),
    .spi_dc_i   (spi_dc_i),
    .byte_stb   (byte_stb),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .cs_high    (cs_high)
  );

  dec_state_t  state, state_nxt;
  logic [15:0] xs, xe, ys, ye, x_cur, y_cur, sh_start;
  logic [15:0] xs_nxt, xe_nxt, ys_nxt, ye_nxt, x_nxt, y_nxt, sh_start_nxt;
  logic [7:0]  sh_end_hi, sh_end_hi_nxt, hi, hi_nxt;
  logic [1:0]  param_idx, param_idx_nxt;
  logic        phase, phase_nxt;
  logic [15:0] win_end;
  logic        cmd_valid_nxt, pixel_valid_nxt, frame_done_nxt, err_nxt;
  logic        disp_on_nxt, sleep_nxt, inv_nxt;
  logic [7:0]  cmd_code_nxt, madctl_nxt, colmod_nxt;
  logic [15:0] pixel_data_nxt, pixel_x_nxt, pixel_y_nxt;

  // Window end as committed by the last CASET/RASET byte; never below start.
  assign win_end = (sh_start > {sh_end_hi, rx_byte}) ? sh_start : {sh_end_hi, rx_byte};

  // State and register file; everything returns to power-on values at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;       cmd_code_o <= 8'h00;    cmd_valid_o <= 1'b0;
      pixel_valid_o <= 1'b0; pixel_data_o <= 16'd0;  pixel_x_o <= 16'd0;
      pixel_y_o <= 16'd0;    frame_done_o <= 1'b0;   err_unexp_o <= 1'b0;
      disp_on_o <= 1'b0;     sleep_o <= 1'b1;        inv_on_o <= 1'b0;
      madctl_o <= MADCTL_RST; colmod_o <= COLMOD_RST;
      xs <= 16'd0; xe <= XE_RST; ys <= 16'd0; ye <= YE_RST;
      x_cur <= 16'd0; y_cur <= 16'd0; phase <= 1'b0; hi <= 8'h00;
      param_idx <= 2'd0; sh_start <= 16'd0; sh_end_hi <= 8'h00;
    end else begin
      state <= state_nxt;    cmd_code_o <= cmd_code_nxt; cmd_valid_o <= cmd_valid_nxt;
      pixel_valid_o <= pixel_valid_nxt; pixel_data_o <= pixel_data_nxt;
      pixel_x_o <= pixel_x_nxt; pixel_y_o <= pixel_y_nxt;
      frame_done_o <= frame_done_nxt; err_unexp_o <= err_nxt;
      disp_on_o <= disp_on_nxt; sleep_o <= sleep_nxt; inv_on_o <= inv_nxt;
      madctl_o <= madctl_nxt; colmod_o <= colmod_nxt;
      xs <= xs_nxt; xe <= xe_nxt; ys <= ys_nxt; ye <= ye_nxt;
      x_cur <= x_nxt; y_cur <= y_nxt; phase <= phase_nxt; hi <= hi_nxt;
      param_idx <= param_idx_nxt; sh_start <= sh_start_nxt; sh_end_hi <= sh_end_hi_nxt;
    end
  end

  // Next-state and register updates for each received byte.
  always_comb begin
    state_nxt = state;        cmd_code_nxt = cmd_code_o;   cmd_valid_nxt = 1'b0;
    pixel_valid_nxt = 1'b0;   pixel_data_nxt = pixel_data_o;
    pixel_x_nxt = pixel_x_o;  pixel_y_nxt = pixel_y_o;
    frame_done_nxt = 1'b0;    err_nxt = 1'b0;
    disp_on_nxt = disp_on_o;  sleep_nxt = sleep_o;         inv_nxt = inv_on_o;
    madctl_nxt = madctl_o;    colmod_nxt = colmod_o;
    xs_nxt = xs; xe_nxt = xe; ys_nxt = ys; ye_nxt = ye;
    x_nxt = x_cur; y_nxt = y_cur; phase_nxt = phase; hi_nxt = hi;
    param_idx_nxt = param_idx; sh_start_nxt = sh_start; sh_end_hi_nxt = sh_end_hi;

    if (byte_stb && !rx_dc) begin
      cmd_code_nxt  = rx_byte;
      cmd_valid_nxt = 1'b1;
      param_idx_nxt = 2'd0;
      phase_nxt     = 1'b0;
      state_nxt     = S_IDLE;
      case (rx_byte)
        CMD_SWRESET: begin
          disp_on_nxt = 1'b0; sleep_nxt = 1'b1; inv_nxt = 1'b0;
          madctl_nxt = MADCTL_RST; colmod_nxt = COLMOD_RST;
          xs_nxt = 16'd0; xe_nxt = XE_RST; ys_nxt = 16'd0; ye_nxt = YE_RST;
          pixel_data_nxt = 16'd0; pixel_x_nxt = 16'd0; pixel_y_nxt = 16'd0;
        end
        CMD_SLPOUT:  sleep_nxt = 1'b0;
        CMD_SLPIN:   sleep_nxt = 1'b1;
        CMD_DISPON:  disp_on_nxt = 1'b1;
        CMD_DISPOFF: disp_on_nxt = 1'b0;
        CMD_INVON:   inv_nxt = 1'b1;
        CMD_INVOFF:  inv_nxt = 1'b0;
        CMD_NORON:   state_nxt = S_IDLE;
        CMD_COLMOD, CMD_MADCTL, CMD_CASET, CMD_RASET: state_nxt = S_PARAM;
        CMD_RAMWR: begin
          state_nxt = S_RAMWR;
          x_nxt = xs;
          y_nxt = ys;
        end
        default:     state_nxt = S_IGNORE;
      endcase
    end else if (byte_stb) begin
      case (state)
        S_IDLE: err_nxt = 1'b1;
        S_PARAM: begin
          param_idx_nxt = param_idx + 2'd1;
          if (cmd_code_o == CMD_COLMOD) begin
            colmod_nxt = rx_byte;
            state_nxt  = S_IDLE;
          end else if (cmd_code_o == CMD_MADCTL) begin
            madctl_nxt = rx_byte;
            state_nxt  = S_IDLE;
          end else begin
            case (param_idx)
              2'd0: sh_start_nxt[15:8] = rx_byte;
              2'd1: sh_start_nxt[7:0]  = rx_byte;
              2'd2: sh_end_hi_nxt      = rx_byte;
              default: begin
                if (cmd_code_o == CMD_CASET) begin
                  xs_nxt = sh_start;
                  xe_nxt = win_end;
                end else begin
                  ys_nxt = sh_start;
                  ye_nxt = win_end;
                end
                state_nxt = S_IDLE;
              end
            endcase
          end
        end
        S_RAMWR: begin
          if (!phase) begin
            hi_nxt    = rx_byte;
            phase_nxt = 1'b1;
          end else begin
            phase_nxt       = 1'b0;
            pixel_valid_nxt = 1'b1;
            pixel_data_nxt  = {hi, rx_byte};
            pixel_x_nxt     = x_cur;
            pixel_y_nxt     = y_cur;
            if (x_cur == xe) begin
              x_nxt = xs;
              if (y_cur == ye) begin
                y_nxt = ys;
                frame_done_nxt = 1'b1;
              end else begin
                y_nxt = y_cur + 16'd1;
              end
            end else begin
              x_nxt = x_cur + 16'd1;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end else if (cs_high) begin
      phase_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_tft_cmd_decoder.sv
// Directed bench for the SPI TFT command decoder: drives SPI bytes at the
// pins and compares registers and the captured pixel stream to fixed values.
module tb_spi_tft_cmd_decoder;

  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, dc = 1'b0;
  logic        cmd_valid_o, pixel_valid_o, frame_done_o, err_unexp_o;
  logic        disp_on_o, sleep_o, inv_on_o;
  logic [7:0]  cmd_code_o, madctl_o, colmod_o;
  logic [15:0] pixel_data_o, pixel_x_o, pixel_y_o;

  int checks = 0, errors = 0;
  int cmd_cnt = 0, pix_cnt = 0, err_cnt = 0;
  logic [15:0] log_d [0:255];
  logic [15:0] log_x [0:255];
  logic [15:0] log_y [0:255];
  logic        log_fd[0:255];

  spi_tft_cmd_decoder dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_sclk_i(sclk), .spi_mosi_i(mosi), .spi_cs_n_i(cs_n), .spi_dc_i(dc),
    .cmd_valid_o(cmd_valid_o), .cmd_code_o(cmd_code_o),
    .pixel_valid_o(pixel_valid_o), .pixel_data_o(pixel_data_o),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .frame_done_o(frame_done_o),
    .disp_on_o(disp_on_o), .sleep_o(sleep_o), .inv_on_o(inv_on_o),
    .madctl_o(madctl_o), .colmod_o(colmod_o), .err_unexp_o(err_unexp_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse monitor, sampled on the falling edge so each 1-cycle pulse is seen once.
  always @(negedge sys_clk) begin
    if (cmd_valid_o) cmd_cnt++;
    if (err_unexp_o) err_cnt++;
    if (pixel_valid_o && pix_cnt < 256) begin
      log_d[pix_cnt] = pixel_data_o;
      log_x[pix_cnt] = pixel_x_o;
      log_y[pix_cnt] = pixel_y_o;
      log_fd[pix_cnt] = frame_done_o;
      pix_cnt++;
    end
  end

  task automatic spi_bits(input logic d, input logic [7:0] data, input int n);
    dc = d;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = data[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] op);
    spi_bits(1'b0, op, 8);
  endtask

  task automatic par(input logic [7:0] b);
    spi_bits(1'b1, b, 8);
  endtask

  task automatic settle();
    repeat (6) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    checks++; if ({cmd_valid_o, pixel_valid_o, frame_done_o, err_unexp_o} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {cmd_valid_o, pixel_valid_o, frame_done_o, err_unexp_o}); end
    checks++; if ({sleep_o, disp_on_o, inv_on_o} !== 3'b100) begin errors++; $display("FAIL reset_sleep_disp_inv: got %b expected 100", {sleep_o, disp_on_o, inv_on_o}); end
    checks++; if ({cmd_code_o, madctl_o, colmod_o} !== 24'h000000) begin errors++; $display("FAIL reset_cmd_madctl_colmod: got %h expected 000000", {cmd_code_o, madctl_o, colmod_o}); end
    checks++; if ({pixel_data_o, pixel_x_o, pixel_y_o} !== 48'd0) begin errors++; $display("FAIL reset_pixel_regs: got %h expected 0", {pixel_data_o, pixel_x_o, pixel_y_o}); end
    sys_rst = 1'b0;
    @(posedge sys_clk);
    cs_n = 1'b0;
    #50;
  endtask

  task automatic test_default_window();
    int p0;
    p0 = pix_cnt;
    cmd(8'h2C); par(8'hAA); par(8'h01); par(8'hBB); par(8'h02);
    settle();
    checks++; if (pix_cnt - p0 !== 2) begin errors++; $display("FAIL defwin_count: got %0d expected 2", pix_cnt - p0); end
    else begin
      checks++; if ({log_x[p0], log_y[p0], log_d[p0]} !== {16'd0, 16'd0, 16'hAA01}) begin errors++; $display("FAIL defwin_px0: got x=%0d y=%0d d=%h expected x=0 y=0 d=aa01", log_x[p0], log_y[p0], log_d[p0]); end
      checks++; if ({log_x[p0+1], log_y[p0+1], log_fd[p0+1]} !== {16'd1, 16'd0, 1'b0}) begin errors++; $display("FAIL defwin_px1: got x=%0d y=%0d fd=%b expected x=1 y=0 fd=0", log_x[p0+1], log_y[p0+1], log_fd[p0+1]); end
    end
  endtask

  task automatic test_init();
    int c0, e0;
    c0 = cmd_cnt; e0 = err_cnt;
    cmd(8'h01); cmd(8'h11);
    cmd(8'h3A); par(8'h55);
    cmd(8'h36); par(8'h78);
    cmd(8'h2A); par(8'h00); par(8'h00); par(8'h01); par(8'h3F);
    cmd(8'h2B); par(8'h00); par(8'h00); par(8'h00); par(8'hEF);
    cmd(8'h21); cmd(8'h13); cmd(8'h29);
    settle();
    checks++; if (cmd_cnt - c0 !== 9) begin errors++; $display("FAIL init_cmd_count: got %0d expected 9", cmd_cnt - c0); end
    checks++; if (colmod_o !== 8'h55) begin errors++; $display("FAIL init_colmod: got %h expected 55", colmod_o); end
    checks++; if (madctl_o !== 8'h78) begin errors++; $display("FAIL init_madctl: got %h expected 78", madctl_o); end
    checks++; if ({inv_on_o, disp_on_o, sleep_o} !== 3'b110) begin errors++; $display("FAIL init_inv_disp_sleep: got %b expected 110", {inv_on_o, disp_on_o, sleep_o}); end
    checks++; if (cmd_code_o !== 8'h29) begin errors++; $display("FAIL init_cmd_code: got %h expected 29", cmd_code_o); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL init_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_window_stream();
    int p0;
    logic [15:0] v;
    p0 = pix_cnt;
    cmd(8'h2A); par(8'h00); par(8'h02); par(8'h00); par(8'h03);
    cmd(8'h2B); par(8'h00); par(8'h05); par(8'h00); par(8'h06);
    cmd(8'h2C);
    for (int i = 0; i < 8; i++) begin
      v = 16'h1234 + 16'(i);
      par(v[15:8]); par(v[7:0]);
    end
    settle();
    checks++; if (pix_cnt - p0 !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", pix_cnt - p0); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({log_d[p0+i], log_x[p0+i], log_y[p0+i], log_fd[p0+i]} !==
            {16'h1234 + 16'(i), 16'd2 + 16'(i % 2), 16'd5 + 16'((i / 2) % 2), (i % 4) == 3}) begin
          errors++;
          $display("FAIL stream_px%0d: got d=%h x=%0d y=%0d fd=%b expected d=%h x=%0d y=%0d fd=%b", i,
                   log_d[p0+i], log_x[p0+i], log_y[p0+i], log_fd[p0+i],
                   16'h1234 + 16'(i), 2 + (i % 2), 5 + ((i / 2) % 2), (i % 4) == 3);
        end
      end
    end
  endtask

  task automatic test_ramwr_odd();
    int p0;
    cmd(8'h28);
    p0 = pix_cnt;
    cmd(8'h2C); par(8'h12); par(8'h34); par(8'h56);
    cmd(8'h29);
    settle();
    checks++; if (pix_cnt - p0 !== 1) begin errors++; $display("FAIL odd_count: got %0d expected 1", pix_cnt - p0); end
    else begin
      checks++; if ({log_d[p0], log_x[p0], log_y[p0]} !== {16'h1234, 16'd2, 16'd5}) begin errors++; $display("FAIL odd_px: got d=%h x=%0d y=%0d expected d=1234 x=2 y=5", log_d[p0], log_x[p0], log_y[p0]); end
    end
    checks++; if (disp_on_o !== 1'b1) begin errors++; $display("FAIL odd_disp_on: got %b expected 1", disp_on_o); end
  endtask

  task automatic test_partial_caset_err();
    int p0, e0;
    p0 = pix_cnt; e0 = err_cnt;
    cmd(8'h2A); par(8'h00); par(8'h07); par(8'h00);
    cmd(8'h2C); par(8'hAB); par(8'hCD);
    settle();
    checks++; if (pix_cnt - p0 !== 1) begin errors++; $display("FAIL partial_count: got %0d expected 1", pix_cnt - p0); end
    else begin
      checks++; if ({log_x[p0], log_y[p0], log_d[p0]} !== {16'd2, 16'd5, 16'hABCD}) begin errors++; $display("FAIL partial_px: got x=%0d y=%0d d=%h expected x=2 y=5 d=abcd", log_x[p0], log_y[p0], log_d[p0]); end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL partial_no_err: got %0d expected 0", err_cnt - e0); end
    cmd(8'h29); par(8'h11);
    settle();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL unexp_err: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_clamp();
    int p0;
    p0 = pix_cnt;
    cmd(8'h2A); par(8'h00); par(8'h05); par(8'h00); par(8'h03);
    cmd(8'h2B); par(8'h00); par(8'h01); par(8'h00); par(8'h01);
    cmd(8'h2C); par(8'h00); par(8'h01); par(8'h00); par(8'h02);
    settle();
    checks++; if (pix_cnt - p0 !== 2) begin errors++; $display("FAIL clamp_count: got %0d expected 2", pix_cnt - p0); end
    else begin
      checks++; if ({log_x[p0], log_y[p0], log_fd[p0]} !== {16'd5, 16'd1, 1'b1}) begin errors++; $display("FAIL clamp_px0: got x=%0d y=%0d fd=%b expected x=5 y=1 fd=1", log_x[p0], log_y[p0], log_fd[p0]); end
      checks++; if ({log_x[p0+1], log_y[p0+1], log_fd[p0+1]} !== {16'd5, 16'd1, 1'b1}) begin errors++; $display("FAIL clamp_px1: got x=%0d y=%0d fd=%b expected x=5 y=1 fd=1", log_x[p0+1], log_y[p0+1], log_fd[p0+1]); end
    end
  endtask

  task automatic test_ignore();
    int e0;
    e0 = err_cnt;
    cmd(8'hB1); par(8'h01); par(8'h02); par(8'h03);
    settle();
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL ignore_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (cmd_code_o !== 8'hB1) begin errors++; $display("FAIL ignore_cmd_code: got %h expected b1", cmd_code_o); end
  endtask

  task automatic test_swreset();
    int p0;
    cmd(8'h21); cmd(8'h11);
    cmd(8'h01);
    settle();
    checks++; if ({disp_on_o, sleep_o, inv_on_o, madctl_o, colmod_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin errors++; $display("FAIL swreset_regs: got disp=%b sleep=%b inv=%b madctl=%h colmod=%h expected 0 1 0 00 00", disp_on_o, sleep_o, inv_on_o, madctl_o, colmod_o); end
    p0 = pix_cnt;
    cmd(8'h2C); par(8'h00); par(8'h10); par(8'h00); par(8'h20);
    settle();
    checks++; if (pix_cnt - p0 !== 2) begin errors++; $display("FAIL swreset_count: got %0d expected 2", pix_cnt - p0); end
    else begin
      checks++; if ({log_x[p0], log_y[p0], log_x[p0+1], log_y[p0+1]} !== {16'd0, 16'd0, 16'd1, 16'd0}) begin errors++; $display("FAIL swreset_coords: got (%0d,%0d),(%0d,%0d) expected (0,0),(1,0)", log_x[p0], log_y[p0], log_x[p0+1], log_y[p0+1]); end
    end
  endtask

  task automatic test_cs_partial_and_reset();
    int c0, p0, e0;
    c0 = cmd_cnt;
    spi_bits(1'b0, 8'hFF, 5);
    cs_n = 1'b1;
    #100;
    cs_n = 1'b0;
    #50;
    cmd(8'hA5);
    settle();
    checks++; if (cmd_code_o !== 8'hA5) begin errors++; $display("FAIL cs_partial_code: got %h expected a5", cmd_code_o); end
    checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL cs_partial_count: got %0d expected 1", cmd_cnt - c0); end
    p0 = pix_cnt;
    cmd(8'h11);
    cmd(8'h2C); par(8'h12); par(8'h34); par(8'h56);
    settle();
    sys_rst = 1'b1;
    #1;
    checks++; if ({sleep_o, cmd_code_o, pixel_data_o} !== {1'b1, 8'h00, 16'h0000}) begin errors++; $display("FAIL midreset_regs: got sleep=%b code=%h data=%h expected 1 00 0000", sleep_o, cmd_code_o, pixel_data_o); end
    repeat (5) @(posedge sys_clk);
    sys_rst = 1'b0;
    #50;
    e0 = err_cnt;
    par(8'h78);
    settle();
    checks++; if (pix_cnt - p0 !== 1) begin errors++; $display("FAIL midreset_pixels: got %0d expected 1", pix_cnt - p0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL midreset_err: got %0d expected 1", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_default_window();
    test_init();
    test_window_stream();
    test_ramwr_odd();
    test_partial_caset_err();
    test_clamp();
    test_ignore();
    test_swreset();
    test_cs_partial_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
